// File: rtl/tick_period_meter.sv
// rtl/tick_period_meter.sv - measures the spacing of rising edges on a tick train
//
// Purpose: receive-side checker for divided-clock tick trains in the same clock domain.
//   Measures clkin cycles between consecutive rising edges of tick_in, reports each
//   period, qualifies it against EXPECTED +/- TOL, declares lock after LOCK_COUNT
//   consecutive good periods and flags a timeout when the ticks stop.
// Ports:
//   clkin        in   clock
//   rst_n        in   asynchronous active-low reset
//   tick_in      in   tick train, synchronous to clkin, any pulse width
//   period       out  last measured period, held until the next measurement
//   period_valid out  one-cycle strobe, period updated this cycle
//   in_tol       out  period lies within EXPECTED +/- TOL, held with period
//   locked       out  LOCK_COUNT consecutive in-tolerance periods seen
//   timeout      out  no rising edge for MAX_PERIOD cycles
module tick_period_meter #(
  parameter int WIDTH      = 16,
  parameter int EXPECTED   = 5000,
  parameter int TOL        = 2,
  parameter int LOCK_COUNT = 4,
  parameter int MAX_PERIOD = 65535
) (
  input  logic             clkin,
  input  logic             rst_n,
  input  logic             tick_in,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             in_tol,
  output logic             locked,
  output logic             timeout
);

  // Tolerance window, clamped to the representable counter range.
  localparam longint TOP    = (longint'(1) << WIDTH) - longint'(1);
  localparam longint LO_RAW = longint'(EXPECTED) - longint'(TOL);
  localparam longint HI_RAW = longint'(EXPECTED) + longint'(TOL);
  localparam longint LO_L   = (LO_RAW < longint'(0)) ? longint'(0) : ((LO_RAW > TOP) ? TOP : LO_RAW);
  localparam longint HI_L   = (HI_RAW < longint'(0)) ? longint'(0) : ((HI_RAW > TOP) ? TOP : HI_RAW);
  localparam logic [WIDTH-1:0] LO   = WIDTH'(LO_L);
  localparam logic [WIDTH-1:0] HI   = WIDTH'(HI_L);
  localparam logic [WIDTH-1:0] MAXP = WIDTH'(MAX_PERIOD);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [MW-1:0] LOCK_V = MW'(LOCK_COUNT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEAS = 2'd1,
    TMO  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic             tick_d;
  logic             tick_edge;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic [MW-1:0]    match_cnt, match_nxt;
  logic [WIDTH-1:0] period_nxt;
  logic             valid_nxt, in_tol_nxt, locked_nxt, timeout_nxt;
  logic             cnt_ok;

  assign tick_edge = tick_in & ~tick_d;
  assign cnt_ok    = (cnt >= LO) && (cnt <= HI);

  // State register
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; an edge coinciding with saturation is a valid measurement.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (tick_edge) state_nxt = MEAS;
      MEAS:    if (!tick_edge && (cnt == MAXP)) state_nxt = TMO;
      TMO:     if (tick_edge) state_nxt = MEAS;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    cnt_nxt     = cnt;
    match_nxt   = match_cnt;
    period_nxt  = period;
    valid_nxt   = 1'b0;
    in_tol_nxt  = in_tol;
    locked_nxt  = locked;
    timeout_nxt = timeout;
    case (state)
      IDLE: begin
        if (tick_edge) cnt_nxt = ONE;
      end
      MEAS: begin
        if (tick_edge) begin
          period_nxt = cnt;
          valid_nxt  = 1'b1;
          in_tol_nxt = cnt_ok;
          cnt_nxt    = ONE;
          if (cnt_ok) begin
            match_nxt = (match_cnt == LOCK_V) ? LOCK_V : match_cnt + 1'b1;
            if (match_nxt == LOCK_V) locked_nxt = 1'b1;
          end else begin
            match_nxt  = '0;
            locked_nxt = 1'b0;
          end
        end else if (cnt == MAXP) begin
          timeout_nxt = 1'b1;
          locked_nxt  = 1'b0;
          match_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      TMO: begin
        // Interval across a timeout is unknown: restart without a strobe.
        if (tick_edge) begin
          cnt_nxt     = ONE;
          timeout_nxt = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // tick_d resets high so a tick already high at release is not an edge.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      tick_d       <= 1'b1;
      cnt          <= '0;
      match_cnt    <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      in_tol       <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      tick_d       <= tick_in;
      cnt          <= cnt_nxt;
      match_cnt    <= match_nxt;
      period       <= period_nxt;
      period_valid <= valid_nxt;
      in_tol       <= in_tol_nxt;
      locked       <= locked_nxt;
      timeout      <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_tick_period_meter.sv
// tb/tb_tick_period_meter.sv - self-checking bench for tick_period_meter
module tb_tick_period_meter;

  localparam int W    = 10;
  localparam int EXP  = 100;
  localparam int TOL  = 2;
  localparam int LOCK = 4;
  localparam int MAXP = 120;

  logic         clkin   = 1'b0;
  logic         rst_n   = 1'b0;
  logic         tick_in = 1'b0;
  logic [W-1:0] period;
  logic         period_valid, in_tol, locked, timeout;

  tick_period_meter #(
    .WIDTH(W), .EXPECTED(EXP), .TOL(TOL), .LOCK_COUNT(LOCK), .MAX_PERIOD(MAXP)
  ) dut (
    .clkin(clkin), .rst_n(rst_n), .tick_in(tick_in), .period(period),
    .period_valid(period_valid), .in_tol(in_tol), .locked(locked), .timeout(timeout)
  );

  always #5 clkin = ~clkin;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: remembers the cycle of the last rising edge and derives
  // every output from elapsed time.
  int  m_cyc = 0, m_last = 0, m_streak = 0, m_p;
  bit  m_prev = 1'b1, m_armed = 1'b0, m_to = 1'b0, m_e;
  int  m_period = 0;
  bit  m_valid = 0, m_tol = 0, m_locked = 0, m_timeout = 0;

  always @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc = 0; m_last = 0; m_streak = 0; m_prev = 1'b1; m_armed = 0; m_to = 0;
      m_period = 0; m_valid = 0; m_tol = 0; m_locked = 0; m_timeout = 0;
    end else begin
      m_e = tick_in && !m_prev;
      m_prev = tick_in;
      m_valid = 0;
      if (m_e) begin
        if (m_armed && !m_to) begin
          m_p = m_cyc - m_last;
          m_period = m_p;
          m_valid = 1;
          m_tol = (m_p >= EXP - TOL) && (m_p <= EXP + TOL);
          if (m_tol) begin
            m_streak = (m_streak < LOCK) ? m_streak + 1 : LOCK;
            if (m_streak == LOCK) m_locked = 1;
          end else begin
            m_streak = 0;
            m_locked = 0;
          end
        end
        m_armed = 1; m_to = 0; m_timeout = 0; m_last = m_cyc;
      end else if (m_armed && !m_to && (m_cyc - m_last == MAXP)) begin
        m_to = 1; m_timeout = 1; m_locked = 0; m_streak = 0;
      end
      m_cyc++;
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clkin) begin
    chk("period", period, m_period);
    chk("period_valid", period_valid, m_valid);
    chk("in_tol", in_tol, m_tol);
    chk("locked", locked, m_locked);
    chk("timeout", timeout, m_timeout);
  end

  // Strobe log for hand-computed expectations
  typedef struct {int p; bit t; bit l;} strobe_t;
  strobe_t sq[$];

  always @(posedge clkin) begin
    #1;
    if (rst_n && period_valid) sq.push_back('{int'(period), in_tol, locked});
  end

  task automatic step(input logic v);
    @(negedge clkin);
    tick_in = v;
  endtask

  // Low for g-1 cycles then a one-cycle high: rising edge g cycles after the previous one.
  task automatic edge_after(input int g);
    repeat (g - 1) step(1'b0);
    step(1'b1);
  endtask

  task automatic sync();
    @(posedge clkin);
    #2;
  endtask

  task automatic chk_q(input string name, input int idx, input int p, input bit t, input bit l);
    if (idx >= sq.size()) begin
      checks++; errors++;
      $display("FAIL %s strobe %0d missing, have %0d", name, idx, sq.size());
    end else begin
      chk({name, "_period"}, sq[idx].p, p);
      chk({name, "_in_tol"}, sq[idx].t, t);
      chk({name, "_locked"}, sq[idx].l, l);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, w;
    // Reset state
    repeat (3) @(negedge clkin);
    chk("rst_period", period, 0);
    chk("rst_valid", period_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_timeout", timeout, 0);
    #2 rst_n = 1'b1;

    // 1: arm, then five 100-cycle periods; lock on the fourth strobe
    sq.delete();
    edge_after(5);
    repeat (5) edge_after(100);
    sync();
    chk("t1_count", sq.size(), 5);
    for (int i = 0; i < 5; i++) chk_q("t1", i, 100, 1, i >= 3);
    chk("t1_timeout", timeout, 0);

    // 2: one 103 breaks lock, four 99s regain it
    sq.delete();
    edge_after(103);
    repeat (4) edge_after(99);
    sync();
    chk("t2_count", sq.size(), 5);
    chk_q("t2_bad", 0, 103, 0, 0);
    for (int i = 1; i < 5; i++) chk_q("t2", i, 99, 1, i == 4);

    // 3: silence -> timeout exactly MAXP cycles after the edge registers
    sq.delete();
    for (int k = 1; k <= 130; k++) begin
      step(1'b0);
      if (k == MAXP) chk("t3_timeout_pre", timeout, 0);
      if (k == MAXP + 1) begin
        chk("t3_timeout_rise", timeout, 1);
        chk("t3_locked", locked, 0);
        chk("t3_period_held", period, 99);
      end
    end
    edge_after(20);
    sync();
    chk("t3_timeout_clear", timeout, 0);
    chk("t3_no_strobe", sq.size(), 0);
    edge_after(100);
    sync();
    chk("t3_count", sq.size(), 1);
    chk_q("t3", 0, 100, 1, 0);

    // 4: 1,0,1,0 gives period 2; then held high -> no edges, timeout
    sq.delete();
    repeat (4) edge_after(2);
    repeat (200) step(1'b1);
    chk("t4_count", sq.size(), 4);
    for (int i = 0; i < 4; i++) chk_q("t4", i, 2, 0, 0);
    chk("t4_timeout", timeout, 1);

    // 5: lock, then async reset mid-interval with tick high
    sq.delete();
    edge_after(5);
    repeat (5) edge_after(100);
    repeat (50) step(1'b0);
    chk("t5_locked_before", locked, 1);
    tick_in = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_period", period, 0);
    chk("t5_rst_in_tol", in_tol, 0);
    chk("t5_rst_locked", locked, 0);
    chk("t5_rst_timeout", timeout, 0);
    repeat (3) @(negedge clkin);
    #2 rst_n = 1'b1;
    sq.delete();
    repeat (10) step(1'b1);
    edge_after(30);
    edge_after(100);
    sync();
    chk("t5_count", sq.size(), 1);
    chk_q("t5", 0, 100, 1, 0);

    // 6: edge exactly at MAXP counts; MAXP+1 times out; tolerance boundaries
    sq.delete();
    edge_after(MAXP);
    sync();
    chk("t6_timeout_at_max", timeout, 0);
    edge_after(MAXP + 1);
    edge_after(98);
    edge_after(102);
    edge_after(103);
    edge_after(97);
    sync();
    chk("t6_count", sq.size(), 5);
    chk_q("t6_max", 0, MAXP, 0, 0);
    chk_q("t6_98", 1, 98, 1, 0);
    chk_q("t6_102", 2, 102, 1, 0);
    chk_q("t6_103", 3, 103, 0, 0);
    chk_q("t6_97", 4, 97, 0, 0);

    // Random pulse trains with occasional async resets; the model checks every cycle
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0:       g = $urandom_range(EXP - TOL - 1, EXP + TOL + 1);
        1:       g = $urandom_range(2, MAXP + 10);
        2:       g = $urandom_range(MAXP - 2, MAXP + 2);
        default: g = EXP;
      endcase
      w = $urandom_range(1, g - 1);
      for (int i = 0; i < g; i++) step(i < w);
      if ($urandom_range(0, 49) == 0) begin
        repeat ($urandom_range(1, 40)) step(1'b0);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clkin);
        #2 rst_n = 1'b1;
      end
    end
    repeat (3) @(negedge clkin);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
